// File: rtl/rr_burst_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter: FSM state encoding
// and a constant-evaluable clog2 reused by other arbiters.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr (mod N),
// optionally ignoring one masked index.
module rr_pick
  import rr_burst_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [IW-1:0] mask_idx,
  input  logic          mask_en,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  int unsigned    p;
  int unsigned    hit;

  always_comb begin
    masked = req;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask_en && mask_idx == IW'(i)) masked[i] = 1'b0;
    end
    // Doubling the vector turns the wrap-around scan into a linear window [ptr, ptr+N).
    dbl   = {masked, masked};
    p     = 32'(ptr);
    found = 1'b0;
    hit   = 0;
    for (int unsigned j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j] && j >= p && j < p + N) begin
        found = 1'b1;
        hit   = j;
      end
    end
    idx    = (hit >= N) ? IW'(hit - N) : IW'(hit);
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = found && (idx == IW'(i));
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester at a time for a burst of beats,
// ending on req_last, request drop, or MAX_BURST beats.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-1:0]                   req,
  input  logic [N-1:0]                   req_last,
  output logic [N-1:0]                   grant,
  output logic                           grant_valid,
  output logic [$clog2(N)-1:0]           grant_id,
  output logic [$clog2(MAX_BURST+1)-1:0] burst_cnt
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_nxt, ptr_inc, pick_ptr, pick_idx, gid_nxt;
  logic [N-1:0]  grant_nxt, pick_onehot;
  logic [CW-1:0] cnt_nxt;
  logic          gv_nxt, pick_found, mask_en, beat, last_beat, rel;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_idx (grant_id),
    .mask_en  (mask_en),
    .found    (pick_found),
    .idx      (pick_idx),
    .onehot   (pick_onehot)
  );

  always_comb begin
    beat      = grant_valid & req[grant_id];
    last_beat = beat & (req_last[grant_id] | (burst_cnt == CW'(MAX_BURST - 1)));
    rel       = ~req[grant_id] | last_beat;
    ptr_inc   = (grant_id == IW'(N - 1)) ? '0 : grant_id + IW'(1);
    pick_ptr  = (state == ST_BUSY) ? ptr_inc : rr_ptr;
    // The releasing holder is only re-picked when nobody else is asking.
    mask_en   = (state == ST_BUSY) && |(req & ~grant);

    state_nxt = state;
    ptr_nxt   = rr_ptr;
    grant_nxt = grant;
    gv_nxt    = grant_valid;
    gid_nxt   = grant_id;
    cnt_nxt   = burst_cnt;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_BUSY;
          grant_nxt = pick_onehot;
          gv_nxt    = 1'b1;
          gid_nxt   = pick_idx;
          cnt_nxt   = '0;
        end
      end
      ST_BUSY: begin
        if (rel) begin
          ptr_nxt = ptr_inc;
          cnt_nxt = '0;
          if (pick_found) begin
            grant_nxt = pick_onehot;
            gid_nxt   = pick_idx;
          end else begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
            gv_nxt    = 1'b0;
            gid_nxt   = '0;
          end
        end else if (beat) begin
          cnt_nxt = burst_cnt + CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= ptr_nxt;
      grant       <= grant_nxt;
      grant_valid <= gv_nxt;
      grant_id    <= gid_nxt;
      burst_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed checks of rr_burst_arbiter (N=4, MAX_BURST=8) plus a constrained
// random run on an N=5 instance checking grant invariants and wait bound.
module tb_rr_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0, req_last = '0, grant;
  logic       gv;
  logic [1:0] gid;
  logic [3:0] cnt;

  logic [4:0] req5 = '0, req_last5 = '0, grant5;
  logic       gv5;
  logic [2:0] gid5;
  logic [3:0] cnt5;

  int unsigned tests = 0;
  int unsigned fails = 0;

  rr_burst_arbiter #(.N(4), .MAX_BURST(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last),
    .grant(grant), .grant_valid(gv), .grant_id(gid), .burst_cnt(cnt)
  );

  rr_burst_arbiter #(.N(5), .MAX_BURST(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .req_last(req_last5),
    .grant(grant5), .grant_valid(gv5), .grant_id(gid5), .burst_cnt(cnt5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req       = '0;
    req_last  = '0;
    req5      = '0;
    req_last5 = '0;
    step();
    rst_n = 1'b1;
  endtask

  logic [3:0]  e;
  logic [4:0]  applied;
  logic        prev_gv;
  int unsigned wait_cnt [5];
  int unsigned max_wait;
  int unsigned exp_id;

  initial begin
    // 1: reset state and asynchronous reset mid-burst
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_valid", 32'(gv), 32'h0);
    check("rst_id", 32'(gid), 32'h0);
    check("rst_cnt", 32'(cnt), 32'h0);
    step();
    rst_n = 1'b1;
    req   = 4'b0100;
    step();
    check("t1_first_grant", 32'(grant), 32'h4);
    check("t1_first_id", 32'(gid), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("t1_async_grant", 32'(grant), 32'h0);
    check("t1_async_valid", 32'(gv), 32'h0);
    check("t1_async_id", 32'(gid), 32'h0);
    check("t1_async_cnt", 32'(cnt), 32'h0);
    req = 4'b0001;
    step();
    check("t1_held_grant", 32'(grant), 32'h0);
    rst_n = 1'b1;
    step();
    check("t1_post_grant", 32'(grant), 32'h1);
    check("t1_post_valid", 32'(gv), 32'h1);

    // 2: all requesting, forced rotation every 8 beats, no bubbles
    reset_dut();
    req = 4'b1111;
    for (int unsigned g = 0; g < 5; g++) begin
      for (int unsigned b = 0; b < 8; b++) begin
        step();
        e = 4'b0001 << (g % 4);
        check("t2_grant", 32'(grant), 32'(e));
        check("t2_id", 32'(gid), g % 4);
        check("t2_cnt", 32'(cnt), b);
      end
    end

    // 3: req_last on holder's 3rd beat; req_last on a non-holder ignored
    reset_dut();
    req = 4'b0101;
    step();
    check("t3_grant0", 32'(grant), 32'h1);
    check("t3_cnt0", 32'(cnt), 32'h0);
    req_last = 4'b0100;
    step();
    check("t3_grant1", 32'(grant), 32'h1);
    check("t3_cnt1", 32'(cnt), 32'h1);
    req_last = 4'b0000;
    step();
    check("t3_cnt2", 32'(cnt), 32'h2);
    req_last = 4'b0001;
    step();
    req_last = 4'b0000;
    check("t3_next_grant", 32'(grant), 32'h4);
    check("t3_next_cnt", 32'(cnt), 32'h0);

    // 4: sole requester re-granted after each MAX_BURST
    reset_dut();
    req = 4'b0010;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      check("t4_valid", 32'(gv), 32'h1);
      check("t4_id", 32'(gid), 32'h1);
      check("t4_cnt", 32'(cnt), i % 8);
    end

    // 5: holder drops while another rises; pointer then restarts at 0
    reset_dut();
    req = 4'b0100;
    step();
    check("t5_grant2", 32'(grant), 32'h4);
    step();
    check("t5_cnt1", 32'(cnt), 32'h1);
    req = 4'b1000;
    step();
    check("t5_grant3", 32'(grant), 32'h8);
    check("t5_drop_not_counted", 32'(cnt), 32'h0);
    req = 4'b0000;
    step();
    check("t5_idle", 32'(gv), 32'h0);
    req = 4'b1001;
    step();
    check("t5_ptr_wrapped", 32'(grant), 32'h1);

    // 6: random traffic on N=5
    reset_dut();
    prev_gv  = 1'b0;
    max_wait = 0;
    for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
    for (int unsigned cyc = 0; cyc < 2000; cyc++) begin
      applied = req5;
      step();
      check("t6_onehot", 32'($onehot0(grant5)), 32'h1);
      check("t6_valid", 32'(gv5), 32'(|grant5));
      exp_id = 0;
      for (int unsigned i = 0; i < 5; i++) if (grant5[i]) exp_id = i;
      check("t6_id", 32'(gid5), exp_id);
      if (!prev_gv && |applied) check("t6_latency", 32'(gv5), 32'h1);
      prev_gv = gv5;
      for (int i = 0; i < 5; i++) begin
        if (applied[i] && !grant5[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        if (grant5[i]) req5[i] = ($urandom_range(7) != 0);
        else if (!req5[i]) req5[i] = ($urandom_range(2) == 0);
        req_last5[i] = ($urandom_range(5) == 0);
      end
    end
    check("t6_max_wait_bound", 32'(max_wait <= 36), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
